// File: rtl/dmem_responder.sv
// Data-memory responder: turns EX/MEM read/write requests into RAM strobes, retrying RAM errors up to a limit.
// Optional one-entry read buffer (write-through) enabled by defining DMEM_LOAD_BUFFER_EN.
module dmem_responder (
    input  logic        CLK,
    input  logic        RST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        dstall,
    output logic        derror,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
    typedef enum logic [1:0] {IDLE, REQ, BACKOFF, DONE} state_t;

    state_t     state;
    ramstate_t  rs;
    logic       is_wr;
    logic [1:0] err_cnt;
    logic       req_vld;

    assign rs      = ramstate_t'(ramstate);
    assign req_vld = dmemREN | dmemWEN;
    assign dstall  = ((state == IDLE) && req_vld) || (state == REQ) || (state == BACKOFF);

`ifdef DMEM_LOAD_BUFFER_EN
    logic        buf_vld;
    logic [31:0] buf_addr;
    logic [31:0] buf_data;
    logic        buf_hit;

    assign buf_hit = buf_vld && dmemREN && !dmemWEN && (dmemaddr == buf_addr);
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            dhit     <= 1'b0;
            derror   <= 1'b0;
            dmemload <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
            is_wr    <= 1'b0;
            err_cnt  <= '0;
`ifdef DMEM_LOAD_BUFFER_EN
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
`endif
        end else begin
            dhit   <= 1'b0;
            derror <= 1'b0;
            case (state)
                IDLE: begin
`ifdef DMEM_LOAD_BUFFER_EN
                    if (buf_hit) begin
                        dmemload <= buf_data;
                        dhit     <= 1'b1;
                        state    <= DONE;
                    end else
`endif
                    if (req_vld) begin
                        // A simultaneous read+write is treated as a write.
                        ramaddr  <= dmemaddr;
                        ramstore <= dmemstore;
                        is_wr    <= dmemWEN;
                        err_cnt  <= '0;
                        ramWEN   <= dmemWEN;
                        ramREN   <= !dmemWEN;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    case (rs)
                        ACCESS: begin
                            ramREN <= 1'b0;
                            ramWEN <= 1'b0;
                            dhit   <= 1'b1;
                            state  <= DONE;
                            if (!is_wr) begin
                                dmemload <= ramload;
                            end
`ifdef DMEM_LOAD_BUFFER_EN
                            if (!is_wr) begin
                                buf_vld  <= 1'b1;
                                buf_addr <= ramaddr;
                                buf_data <= ramload;
                            end else if (buf_vld && (buf_addr == ramaddr)) begin
                                buf_data <= ramstore;
                            end
`endif
                        end
                        ERROR: begin
                            ramREN  <= 1'b0;
                            ramWEN  <= 1'b0;
                            err_cnt <= err_cnt + 2'd1;
                            if (err_cnt == 2'd2) begin
                                dhit   <= 1'b1;
                                derror <= 1'b1;
                                state  <= DONE;
`ifdef DMEM_LOAD_BUFFER_EN
                                buf_vld <= 1'b0;
`endif
                            end else begin
                                state <= BACKOFF;
                            end
                        end
                        default: ;
                    endcase
                end
                BACKOFF: begin
                    ramWEN <= is_wr;
                    ramREN <= !is_wr;
                    state  <= REQ;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: scripted RAM responses, scoreboard of completions, cycle-level strobe/latency checks.
// Expectations follow DMEM_LOAD_BUFFER_EN when the bench is built with the macro defined.
module tb_dmem_responder;

    localparam logic [1:0] RS_FREE   = 2'd0;
    localparam logic [1:0] RS_BUSY   = 2'd1;
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    logic        CLK;
    logic        RST;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        dstall;
    logic        derror;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    int          n_checks = 0;
    int          n_errs   = 0;
    logic [32:0] sb_q[$];
    logic [32:0] sb_exp;
    logic [31:0] exp_load;

`ifdef DMEM_LOAD_BUFFER_EN
    logic        mdl_buf_vld;
    logic [31:0] mdl_buf_addr;
    logic [31:0] mdl_buf_data;
`endif

    dmem_responder dut (
        .CLK       (CLK),
        .RST       (RST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .dstall    (dstall),
        .derror    (derror),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Completion monitor: every dhit pops one expected {derror, dmemload}.
    always @(negedge CLK) begin
        if (!RST) begin
            if (dhit) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexp_dhit", {31'd0, dhit}, 32'd0);
                end else begin
                    sb_exp = sb_q.pop_front();
                    check_eq("dmemload", dmemload, sb_exp[31:0]);
                    check_eq("derror", {31'd0, derror}, {31'd0, sb_exp[32]});
                end
            end else if (derror) begin
                check_eq("derror_nohit", {31'd0, derror}, 32'd0);
            end
        end
    end

    // One access: request driven in cycle 0, RAM answers BUSY nbusy times, then ERROR nerr times, then ACCESS.
    task automatic access(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int nbusy, input int nerr);
        int   busy;
        int   errs;
        int   lat;
        int   exp_strb;
        int   strobes;
        logic hit_buf;
        logic exp_e;
        logic done;
        busy    = nbusy;
        errs    = nerr;
        hit_buf = 1'b0;
        @(negedge CLK);
`ifdef DMEM_LOAD_BUFFER_EN
        hit_buf = re && !we && mdl_buf_vld && (mdl_buf_addr == addr);
`endif
        exp_e    = !hit_buf && (nerr >= 3);
        lat      = hit_buf ? 1 : 2 + nbusy + 2 * ((nerr > 2) ? 2 : nerr);
        exp_strb = hit_buf ? 0 : nbusy + ((nerr >= 3) ? 3 : nerr) + ((nerr >= 3) ? 0 : 1);
        if (hit_buf) begin
`ifdef DMEM_LOAD_BUFFER_EN
            exp_load = mdl_buf_data;
`endif
        end else if (exp_e) begin
`ifdef DMEM_LOAD_BUFFER_EN
            mdl_buf_vld = 1'b0;
`endif
        end else if (!we) begin
            exp_load = rdata;
`ifdef DMEM_LOAD_BUFFER_EN
            mdl_buf_vld  = 1'b1;
            mdl_buf_addr = addr;
            mdl_buf_data = rdata;
`endif
        end else begin
`ifdef DMEM_LOAD_BUFFER_EN
            if (mdl_buf_vld && (mdl_buf_addr == addr)) mdl_buf_data = wdata;
`endif
        end
        sb_q.push_back({exp_e, exp_load});
        check_eq("dhit_idle", {31'd0, dhit}, 32'd0);
        dmemWEN   = we;
        dmemREN   = re;
        dmemaddr  = addr;
        dmemstore = wdata;
        ramstate  = RS_FREE;
        #1 check_eq("dstall_req", {31'd0, dstall}, 32'd1);
        done    = 1'b0;
        strobes = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge CLK);
            if (ramREN || ramWEN) begin
                strobes++;
                check_eq("ramWEN", {31'd0, ramWEN}, {31'd0, we});
                check_eq("ramREN", {31'd0, ramREN}, {31'd0, re && !we});
                check_eq("ramaddr", ramaddr, addr);
                if (we) check_eq("ramstore", ramstore, wdata);
                if (busy > 0) begin
                    ramstate = RS_BUSY;
                    busy--;
                end else if (errs > 0) begin
                    ramstate = RS_ERROR;
                    ramload  = $urandom;
                    errs--;
                end else begin
                    ramstate = RS_ACCESS;
                    ramload  = we ? $urandom : rdata;
                end
            end else begin
                ramstate = RS_FREE;
            end
            if (dhit) begin
                done = 1'b1;
                check_eq("latency", cyc, lat);
                check_eq("strobe_cycles", strobes, exp_strb);
                check_eq("dstall_done", {31'd0, dstall}, 32'd0);
            end else begin
                check_eq("dstall_busy", {31'd0, dstall}, 32'd1);
            end
            // Latched access must not follow the request inputs once out of IDLE.
            dmemaddr  = ~addr;
            dmemstore = ~wdata;
        end
        if (!done) check_eq("timeout", 32'd0, 32'd1);
    endtask

    task automatic go_idle(input int n);
        @(negedge CLK);
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        ramstate = RS_FREE;
        repeat (n) @(negedge CLK);
    endtask

    task automatic reset_mid_access();
        @(negedge CLK);
        dmemREN  = 1'b1;
        dmemWEN  = 1'b0;
        dmemaddr = 32'h0000_0200;
        @(negedge CLK);
        ramstate = RS_BUSY;
        check_eq("rst_pre_ren", {31'd0, ramREN}, 32'd1);
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check_eq("rst_ren", {31'd0, ramREN}, 32'd0);
        check_eq("rst_wen", {31'd0, ramWEN}, 32'd0);
        check_eq("rst_dhit", {31'd0, dhit}, 32'd0);
        check_eq("rst_load", dmemload, 32'd0);
        check_eq("rst_ramaddr", ramaddr, 32'd0);
        dmemREN  = 1'b0;
        ramstate = RS_FREE;
        #1 check_eq("rst_dstall", {31'd0, dstall}, 32'd0);
        exp_load = '0;
`ifdef DMEM_LOAD_BUFFER_EN
        mdl_buf_vld = 1'b0;
`endif
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        RST       = 1'b1;
        dmemREN   = 1'b0;
        dmemWEN   = 1'b0;
        dmemaddr  = '0;
        dmemstore = '0;
        ramload   = '0;
        ramstate  = RS_FREE;
        exp_load  = '0;
`ifdef DMEM_LOAD_BUFFER_EN
        mdl_buf_vld  = 1'b0;
        mdl_buf_addr = '0;
        mdl_buf_data = '0;
`endif
        #1;
        check_eq("init_dhit", {31'd0, dhit}, 32'd0);
        check_eq("init_derror", {31'd0, derror}, 32'd0);
        check_eq("init_load", dmemload, 32'd0);
        check_eq("init_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
        check_eq("init_ramaddr", ramaddr, 32'd0);
        check_eq("init_ramstore", ramstore, 32'd0);
        check_eq("init_dstall", {31'd0, dstall}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;

        access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 0);
        access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 0, 0);
        access(1'b1, 1'b0, 32'h0000_0080, 32'h1234_5678, 32'h0, 3, 0);
        access(1'b0, 1'b1, 32'h0000_0100, 32'h0, 32'hBAD0_BAD0, 0, 3);
        access(1'b1, 1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 32'h0, 0, 0);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h0BAD_F00D, 1, 1);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h55AA_55AA, 32'h0, 0, 2);
        access(1'b0, 1'b1, 32'h0000_0020, 32'h0, 32'h1111_1111, 0, 0);
        go_idle(2);
        access(1'b1, 1'b0, 32'h0000_0030, 32'hFFFF_0000, 32'h0, 1, 3);
        access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h7777_8888, 2, 0);
        go_idle(1);
        reset_mid_access();
        access(1'b0, 1'b1, 32'h0000_0044, 32'h0, 32'h4444_4444, 0, 0);
        go_idle(3);

        check_eq("sb_leftover", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
